// File: rtl/ysyx_mcycle_ctrl_if.sv
// Handshake and strobe bundle between the multi-cycle controller and its
// fetch/decode/data-memory/writeback neighbours.
interface ysyx_mcycle_ctrl_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic        imem_rsp_err;
  logic        ir_wr_en;
  logic        dec_rf_wr_en;
  logic        dec_do_jump;
  logic [2:0]  dec_dm_rd_sel;
  logic [1:0]  dec_dm_wr_sel;
  logic        dec_ebreak;
  logic        dmem_req_valid;
  logic        dmem_req_we;
  logic        dmem_req_ready;
  logic        dmem_rsp_valid;
  logic        rf_wr_commit;
  logic        pc_wr_en;
  logic        pc_sel_jump;
  logic        halt;
  logic [1:0]  halt_cause;
  logic [31:0] instret;
  logic [2:0]  state;

  modport master (
    output imem_req_valid, ir_wr_en, dmem_req_valid, dmem_req_we,
           rf_wr_commit, pc_wr_en, pc_sel_jump, halt, halt_cause, instret, state,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_err,
           dec_rf_wr_en, dec_do_jump, dec_dm_rd_sel, dec_dm_wr_sel, dec_ebreak,
           dmem_req_ready, dmem_rsp_valid
  );

  modport slave (
    input  imem_req_valid, ir_wr_en, dmem_req_valid, dmem_req_we,
           rf_wr_commit, pc_wr_en, pc_sel_jump, halt, halt_cause, instret, state,
    output imem_req_ready, imem_rsp_valid, imem_rsp_err,
           dec_rf_wr_en, dec_do_jump, dec_dm_rd_sel, dec_dm_wr_sel, dec_ebreak,
           dmem_req_ready, dmem_rsp_valid
  );
endinterface

// File: rtl/ysyx_mcycle_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback,
// with per-handshake stall timeout and sticky halt.
//
// state  | meaning
// IDLE   | post-reset settle cycle; also parked here while halted
// FETCH  | imem request held until accepted
// FWAIT  | waiting for instruction response; latches IR on success
// DECODE | one cycle; ebreak halts here
// EXEC   | one cycle; routes to MEM for loads/stores
// MEM    | dmem request held until accepted
// MWAIT  | waiting for data response
// WB     | commit, PC update, retire count
module ysyx_mcycle_ctrl #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  ysyx_mcycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FWAIT  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_MWAIT  = 3'd6,
    S_WB     = 3'd7
  } state_e;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] instret_q;
  logic [15:0] wait_q;
  logic        armed_q;

  logic is_load, is_store, mem_op;
  logic waiting, exit_evt, timed_out, retire;
  logic imem_req_valid, ir_wr_en, dmem_req_valid, dmem_req_we;
  logic pc_wr_en, pc_sel_jump, rf_wr_commit;

  // A row with both selects set is treated as a load.
  assign is_load  = bus.dec_dm_rd_sel != 3'd0;
  assign is_store = (bus.dec_dm_wr_sel != 2'd0) && !is_load;
  assign mem_op   = is_load || (bus.dec_dm_wr_sel != 2'd0);

  always_comb begin
    waiting  = 1'b0;
    exit_evt = 1'b0;
    case (state_q)
      S_FETCH: begin waiting = 1'b1; exit_evt = bus.imem_req_ready; end
      S_FWAIT: begin waiting = 1'b1; exit_evt = bus.imem_rsp_valid; end
      S_MEM:   begin waiting = 1'b1; exit_evt = bus.dmem_req_ready; end
      S_MWAIT: begin waiting = 1'b1; exit_evt = bus.dmem_rsp_valid; end
      default: ;
    endcase
  end

  // The exit event wins over an expiring counter in the same cycle.
  assign timed_out = waiting && !exit_evt && (wait_q == WAIT_LAST);

  always_comb begin
    state_d        = state_q;
    halt_d         = halt_q;
    cause_d        = cause_q;
    imem_req_valid = 1'b0;
    ir_wr_en       = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_req_we    = 1'b0;
    pc_wr_en       = 1'b0;
    pc_sel_jump    = 1'b0;
    rf_wr_commit   = 1'b0;
    retire         = 1'b0;
    if (!halt_q) begin
      case (state_q)
        S_IDLE: if (armed_q) state_d = S_FETCH;
        S_FETCH: begin
          imem_req_valid = 1'b1;
          if (bus.imem_req_ready) state_d = S_FWAIT;
        end
        S_FWAIT: begin
          if (bus.imem_rsp_valid) begin
            if (bus.imem_rsp_err) begin
              state_d = S_IDLE;
              halt_d  = 1'b1;
              cause_d = 2'd2;
            end else begin
              ir_wr_en = 1'b1;
              state_d  = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          if (bus.dec_ebreak) begin
            state_d = S_IDLE;
            halt_d  = 1'b1;
            cause_d = 2'd1;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: state_d = mem_op ? S_MEM : S_WB;
        S_MEM: begin
          dmem_req_valid = 1'b1;
          dmem_req_we    = is_store;
          if (bus.dmem_req_ready) state_d = S_MWAIT;
        end
        S_MWAIT: if (bus.dmem_rsp_valid) state_d = S_WB;
        S_WB: begin
          pc_wr_en     = 1'b1;
          pc_sel_jump  = bus.dec_do_jump;
          rf_wr_commit = bus.dec_rf_wr_en && !is_store;
          retire       = 1'b1;
          state_d      = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
      if (timed_out) begin
        state_d = S_IDLE;
        halt_d  = 1'b1;
        cause_d = 2'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      halt_q    <= 1'b0;
      cause_q   <= 2'd0;
      instret_q <= 32'd0;
      wait_q    <= 16'd0;
      armed_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      cause_q <= cause_d;
      armed_q <= 1'b1;
      if (retire) instret_q <= instret_q + 32'd1;
      if (state_d != state_q) wait_q <= 16'd0;
      else if (waiting && wait_q != WAIT_LAST) wait_q <= wait_q + 16'd1;
    end
  end

  assign bus.imem_req_valid = imem_req_valid;
  assign bus.ir_wr_en       = ir_wr_en;
  assign bus.dmem_req_valid = dmem_req_valid;
  assign bus.dmem_req_we    = dmem_req_we;
  assign bus.pc_wr_en       = pc_wr_en;
  assign bus.pc_sel_jump    = pc_sel_jump;
  assign bus.rf_wr_commit   = rf_wr_commit;
  assign bus.halt           = halt_q;
  assign bus.halt_cause     = cause_q;
  assign bus.instret        = instret_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_ysyx_mcycle_ctrl.sv
// Directed bench for ysyx_mcycle_ctrl: instruction table plus hand sequences
// for timeout boundaries, halts, reset mid-handshake and retire-count wrap.
module tb_ysyx_mcycle_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [31:0] exp_instret;

  ysyx_mcycle_ctrl_if bus ();

  ysyx_mcycle_ctrl #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rf;
    logic       jump;
    logic [2:0] rd;
    logic [1:0] wr;
    int         delay;
    int         exp_cycles;
    int         exp_mem;
    logic       exp_we;
    logic       exp_commit;
    logic       exp_jump;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    bus.dec_rf_wr_en   = 1'b0;
    bus.dec_do_jump    = 1'b0;
    bus.dec_dm_rd_sel  = 3'd0;
    bus.dec_dm_wr_sel  = 2'd0;
    bus.dec_ebreak     = 1'b0;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
  endtask

  // Reset, release on a falling edge, and leave the bench 1 ns after the
  // falling edge that follows the first FETCH cycle's rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();
    exp_instret = 32'd0;
  endtask

  function automatic logic [2:0] exp_st(input int mem, input int i);
    if (i < 4) return 3'(i + 1);
    if (mem == 0) return 3'd7;
    if (i < 4 + mem) return 3'd5;
    if (i == 4 + mem) return 3'd6;
    return 3'd7;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int   seq_err, strobe_err, mem_cnt, ir_cnt;
    logic we_seen, commit_seen, jump_seen;
    logic [2:0] st;
    seq_err = 0; strobe_err = 0; mem_cnt = 0; ir_cnt = 0;
    we_seen = 1'b0; commit_seen = 1'b0; jump_seen = 1'b0;
    for (int c = 0; c < v.exp_cycles; c++) begin
      st = exp_st(v.exp_mem, c);
      bus.dec_rf_wr_en   = v.rf;
      bus.dec_do_jump    = v.jump;
      bus.dec_dm_rd_sel  = v.rd;
      bus.dec_dm_wr_sel  = v.wr;
      bus.dec_ebreak     = 1'b0;
      bus.imem_rsp_err   = 1'b0;
      bus.imem_req_ready = (st == 3'd1);
      bus.imem_rsp_valid = (st == 3'd2);
      bus.dmem_req_ready = (st == 3'd5) && (c - 4 == v.delay);
      bus.dmem_rsp_valid = (st == 3'd6);
      #1;
      if (bus.state !== st) seq_err++;
      if (bus.imem_req_valid !== (st == 3'd1) || bus.dmem_req_valid !== (st == 3'd5) ||
          bus.pc_wr_en !== (st == 3'd7) || bus.halt !== 1'b0) strobe_err++;
      if (bus.ir_wr_en) ir_cnt++;
      if (bus.dmem_req_valid) begin mem_cnt++; we_seen = bus.dmem_req_we; end
      if (bus.rf_wr_commit && st != 3'd7) strobe_err++;
      if (st == 3'd7) begin commit_seen = bus.rf_wr_commit; jump_seen = bus.pc_sel_jump; end
      cyc();
    end
    clear_inputs();
    exp_instret = exp_instret + 32'd1;
    chk($sformatf("v%0d_state_seq_errs", idx), 32'(seq_err), 32'd0);
    chk($sformatf("v%0d_strobe_errs", idx), 32'(strobe_err), 32'd0);
    chk($sformatf("v%0d_ir_wr_en_count", idx), 32'(ir_cnt), 32'd1);
    chk($sformatf("v%0d_dmem_valid_cycles", idx), 32'(mem_cnt), 32'(v.exp_mem));
    if (v.exp_mem > 0) chk($sformatf("v%0d_dmem_we", idx), 32'(we_seen), 32'(v.exp_we));
    chk($sformatf("v%0d_rf_wr_commit", idx), 32'(commit_seen), 32'(v.exp_commit));
    chk($sformatf("v%0d_pc_sel_jump", idx), 32'(jump_seen), 32'(v.exp_jump));
    chk($sformatf("v%0d_instret", idx), bus.instret, exp_instret);
    chk($sformatf("v%0d_back_in_fetch", idx), 32'(bus.state), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int errs;
    n_cmp = 0;
    n_bad = 0;
    exp_instret = 32'd0;
    //          rf    jump  rd    wr    dly cyc mem we    commit jump
    vecs[0] = '{1'b1, 1'b0, 3'd0, 2'd0, 0,  5,  0,  1'b0, 1'b1, 1'b0}; // ALU
    vecs[1] = '{1'b1, 1'b1, 3'd0, 2'd0, 0,  5,  0,  1'b0, 1'b1, 1'b1}; // jal
    vecs[2] = '{1'b0, 1'b1, 3'd0, 2'd0, 0,  5,  0,  1'b0, 1'b0, 1'b1}; // taken branch
    vecs[3] = '{1'b1, 1'b0, 3'd5, 2'd0, 3,  10, 4,  1'b0, 1'b1, 1'b0}; // lw, ready late
    vecs[4] = '{1'b0, 1'b0, 3'd0, 2'd3, 0,  7,  1,  1'b1, 1'b0, 1'b0}; // sw
    vecs[5] = '{1'b1, 1'b0, 3'd0, 2'd2, 1,  8,  2,  1'b1, 1'b0, 1'b0}; // store, rf_wr_en ignored
    vecs[6] = '{1'b1, 1'b0, 3'd1, 2'd1, 1,  8,  2,  1'b0, 1'b1, 1'b0}; // both sels: load wins

    // Reset values, with inputs toggling during reset.
    rst_n = 1'b0;
    clear_inputs();
    bus.imem_req_ready = 1'b1;
    bus.dmem_req_ready = 1'b1;
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_halt", 32'(bus.halt), 32'd0);
    chk("rst_cause", 32'(bus.halt_cause), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_strobes", {27'd0, bus.imem_req_valid, bus.dmem_req_valid, bus.pc_wr_en,
                        bus.rf_wr_commit, bus.ir_wr_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("idle_after_first_edge", 32'(bus.imem_req_valid), 32'd0);
    cyc();
    chk("fetch_after_second_edge", 32'(bus.imem_req_valid), 32'd1);
    clear_inputs();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // FETCH stalls past the limit: four FETCH cycles, then timeout halt.
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.imem_req_valid !== 1'b1 || bus.halt !== 1'b0) errs++;
      cyc();
    end
    chk("fetch_stall_valid_errs", 32'(errs), 32'd0);
    chk("timeout_halt", 32'(bus.halt), 32'd1);
    chk("timeout_cause", 32'(bus.halt_cause), 32'd3);
    chk("timeout_state", 32'(bus.state), 32'd0);
    errs = 0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.dmem_req_ready = 1'b1;
    bus.dmem_rsp_valid = 1'b1;
    bus.dec_rf_wr_en   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req_valid || bus.ir_wr_en || bus.dmem_req_valid || bus.pc_wr_en ||
          bus.rf_wr_commit || bus.halt !== 1'b1 || bus.halt_cause !== 2'd3 ||
          bus.instret !== exp_instret) errs++;
      cyc();
    end
    chk("halt_sticky_errs", 32'(errs), 32'd0);

    // Exit events landing exactly on the last allowed stall cycle.
    do_reset();
    bus.imem_req_ready = 1'b0;
    cyc(); cyc(); cyc();
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    chk("fetch_edge_exit_state", 32'(bus.state), 32'd2);
    chk("fetch_edge_exit_halt", 32'(bus.halt), 32'd0);
    cyc(); cyc(); cyc();
    bus.imem_rsp_valid = 1'b1;
    bus.dec_rf_wr_en   = 1'b1;
    #1;
    chk("fwait_edge_ir_wr_en", 32'(bus.ir_wr_en), 32'd1);
    cyc();
    bus.imem_rsp_valid = 1'b0;
    chk("fwait_edge_exit_state", 32'(bus.state), 32'd3);
    cyc();
    cyc();
    chk("edge_wb_commit", 32'(bus.rf_wr_commit), 32'd1);
    cyc();
    chk("edge_instret", bus.instret, 32'd1);
    clear_inputs();

    // Instruction fetch error.
    do_reset();
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_err   = 1'b1;
    #1;
    chk("imem_err_no_ir_wr", 32'(bus.ir_wr_en), 32'd0);
    cyc();
    chk("imem_err_halt", {30'd0, bus.halt, bus.state == 3'd0}, 32'd3);
    chk("imem_err_cause", 32'(bus.halt_cause), 32'd2);
    clear_inputs();

    // ebreak after one retired instruction.
    do_reset();
    run_vec(vecs[0], 10);
    bus.dec_ebreak     = 1'b1;
    bus.dec_rf_wr_en   = 1'b1;
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_rsp_valid = 1'b1;
    cyc();
    bus.imem_rsp_valid = 1'b0;
    chk("ebreak_in_decode", 32'(bus.state), 32'd3);
    cyc();
    chk("ebreak_halt", 32'(bus.halt), 32'd1);
    chk("ebreak_cause", 32'(bus.halt_cause), 32'd1);
    errs = 0;
    bus.dec_ebreak = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req_valid || bus.pc_wr_en || bus.rf_wr_commit) errs++;
      cyc();
    end
    chk("ebreak_quiet_errs", 32'(errs), 32'd0);
    chk("ebreak_instret", bus.instret, exp_instret);
    clear_inputs();

    // lw stalled in MWAIT, then reset pulsed.
    do_reset();
    run_vec(vecs[0], 11);
    bus.dec_dm_rd_sel  = 3'd5;
    bus.dec_rf_wr_en   = 1'b1;
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    cyc();
    bus.imem_rsp_valid = 1'b0;
    cyc();
    cyc();
    chk("lw_in_mem", 32'(bus.state), 32'd5);
    bus.dmem_rsp_valid = 1'b1;
    cyc();
    chk("mem_ignores_rsp", 32'(bus.state), 32'd5);
    bus.dmem_rsp_valid = 1'b0;
    bus.dmem_req_ready = 1'b1;
    cyc();
    bus.dmem_req_ready = 1'b0;
    chk("lw_in_mwait", 32'(bus.state), 32'd6);
    chk("mwait_instret", bus.instret, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mwait_rst_state", 32'(bus.state), 32'd0);
    chk("mwait_rst_instret", bus.instret, 32'd0);
    chk("mwait_rst_outs", {28'd0, bus.halt, bus.dmem_req_valid, bus.pc_wr_en,
                           bus.imem_req_valid}, 32'd0);
    clear_inputs();

    // Retire counter wraps from all-ones to zero.
    do_reset();
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    chk("instret_preset", bus.instret, 32'hFFFF_FFFF);
    exp_instret = 32'hFFFF_FFFF;
    run_vec(vecs[0], 12);
    chk("instret_wrap", bus.instret, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
